// File: rtl/clock_time_scanner.sv
// MM:SS BCD clock with a 4-digit multiplexed 7-segment scanner.
// Latency: time updates 1 clk after a divided_clk rise; an/seg/dp are registered (1 clk behind index/time).
// No backpressure: slow inputs are edge-detected on clk and acted on immediately.
module clock_time_scanner #(
  parameter int COMMON_ANODE = 1,
  parameter int BLANK_LZ     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        divided_clk,
  input  logic        digit_clk,
  input  logic        run,
  input  logic        min_inc,
  output logic [15:0] mm_ss,
  output logic        hour_tick,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  // Display registers hold active-low values; a constant mask flips them for common-cathode parts.
  localparam logic POL_INV = (COMMON_ANODE == 0);

  logic       prev_div_q, prev_dig_q;
  logic [3:0] sec_ones_q, sec_tens_q, min_ones_q, min_tens_q;
  logic [3:0] sec_ones_d, sec_tens_d, min_ones_d, min_tens_d;
  logic       hour_tick_q, hour_tick_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;

  logic       sec_edge, dig_edge, sec_carry;
  logic [1:0] min_add;
  logic [8:0] min_p1, min_p2;
  logic [3:0] digit_sel;

  // Adds one minute to {tens, ones}; bit 8 flags the 59 -> 00 wrap.
  function automatic logic [8:0] min_plus1(input logic [7:0] m);
    logic [3:0] t, o;
    logic       w;
    t = m[7:4];
    o = m[3:0];
    w = 1'b0;
    if (o >= 4'd9) begin
      o = 4'd0;
      if (t >= 4'd5) begin
        t = 4'd0;
        w = 1'b1;
      end else begin
        t = t + 4'd1;
      end
    end else begin
      o = o + 4'd1;
    end
    return {w, t, o};
  endfunction

  // Active-low segment pattern {g,f,e,d,c,b,a}; anything outside 0-9 goes dark.
  function automatic logic [6:0] seg_enc(input logic [3:0] v);
    case (v)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Next-state for the time digits and hour tick; a seconds carry and min_inc may both add a minute.
  always_comb begin
    sec_edge    = divided_clk & ~prev_div_q;
    sec_ones_d  = sec_ones_q;
    sec_tens_d  = sec_tens_q;
    min_ones_d  = min_ones_q;
    min_tens_d  = min_tens_q;
    hour_tick_d = 1'b0;
    sec_carry   = 1'b0;

    if (sec_edge && run) begin
      if (sec_ones_q >= 4'd9) begin
        sec_ones_d = 4'd0;
        if (sec_tens_q >= 4'd5) begin
          sec_tens_d = 4'd0;
          sec_carry  = 1'b1;
        end else begin
          sec_tens_d = sec_tens_q + 4'd1;
        end
      end else begin
        sec_ones_d = sec_ones_q + 4'd1;
      end
    end

    min_add = {1'b0, min_inc} + {1'b0, sec_carry};
    min_p1  = min_plus1({min_tens_q, min_ones_q});
    min_p2  = min_plus1(min_p1[7:0]);

    case (min_add)
      2'd1: begin
        {min_tens_d, min_ones_d} = min_p1[7:0];
        hour_tick_d              = min_p1[8];
      end
      2'd2: begin
        {min_tens_d, min_ones_d} = min_p2[7:0];
        hour_tick_d              = min_p1[8] | min_p2[8];
      end
      default: ;
    endcase
  end

  // Next-state for the scan index and the registered digit drive.
  always_comb begin
    dig_edge = digit_clk & ~prev_dig_q;
    idx_d    = dig_edge ? idx_q + 2'd1 : idx_q;

    case (idx_q)
      2'd0:    begin digit_sel = sec_ones_q; an_d = 4'b1110; end
      2'd1:    begin digit_sel = sec_tens_q; an_d = 4'b1101; end
      2'd2:    begin digit_sel = min_ones_q; an_d = 4'b1011; end
      default: begin digit_sel = min_tens_q; an_d = 4'b0111; end
    endcase

    if ((BLANK_LZ != 0) && (idx_q == 2'd3) && (min_tens_q == 4'd0)) begin
      seg_d = 7'h7F;
    end else begin
      seg_d = seg_enc(digit_sel);
    end

    // Colon blinks with the seconds square wave, shown only on the min_ones digit.
    dp_d = ~((idx_q == 2'd2) && divided_clk);
  end

  // State update; reset wins over every event and primes the edge detectors with live input levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_div_q  <= divided_clk;
      prev_dig_q  <= digit_clk;
      sec_ones_q  <= 4'd0;
      sec_tens_q  <= 4'd0;
      min_ones_q  <= 4'd0;
      min_tens_q  <= 4'd0;
      hour_tick_q <= 1'b0;
      idx_q       <= 2'd0;
      an_q        <= 4'b1111;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
    end else begin
      prev_div_q  <= divided_clk;
      prev_dig_q  <= digit_clk;
      sec_ones_q  <= sec_ones_d;
      sec_tens_q  <= sec_tens_d;
      min_ones_q  <= min_ones_d;
      min_tens_q  <= min_tens_d;
      hour_tick_q <= hour_tick_d;
      idx_q       <= idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign mm_ss     = {min_tens_q, min_ones_q, sec_tens_q, sec_ones_q};
  assign hour_tick = hour_tick_q;
  assign an        = an_q  ^ {4{POL_INV}};
  assign seg       = seg_q ^ {7{POL_INV}};
  assign dp        = dp_q  ^ POL_INV;

endmodule

// File: doc/clock_time_scanner.md
CLOCK_TIME_SCANNER -- requirements
Module: clock_time_scanner

Interface
REQ-001 Parameter COMMON_ANODE, default 1, 1 = an/seg/dp active-low; 0 = all three inverted (active-high).
REQ-002 Parameter BLANK_LZ, default 1, 1 = minute-tens digit blanked when its value is 0.
REQ-003 clk  input  1  system clock, the single clock of the block.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 divided_clk  input  1  slow square wave from the divider, same clk domain; each rising edge = one second.
REQ-006 digit_clk  input  1  fast square wave from the divider, same clk domain; each rising edge = advance scan digit.
REQ-007 run  input  1  level; 1 = seconds advance on divided_clk edges.
REQ-008 min_inc  input  1  one-cycle pulse; add one minute.
REQ-009 mm_ss  output  16  BCD time {min_tens, min_ones, sec_tens, sec_ones}.
REQ-010 hour_tick  output  1  one-cycle pulse when minutes wrap 59 -> 00.
REQ-011 an  output  4  digit enables, one active per cycle.
REQ-012 seg  output  7  segments {g,f,e,d,c,b,a}.
REQ-013 dp  output  1  decimal point / colon.

Function
REQ-014 Edge detect: a prev register per slow input; sec_edge = divided_clk & ~prev_div; dig_edge = digit_clk & ~prev_dig; both inputs are used as data only, never as clocks.
REQ-015 On sec_edge with run=1, seconds increment at the next clk edge (1-cycle latency from the input rising); with run=0, sec_edge is ignored.
REQ-016 BCD rules: sec_ones 0-9, sec_tens 0-5, min_ones 0-9, min_tens 0-5; 9 -> 0 carries to tens; 59 seconds -> 00 carries one minute.
REQ-017 min_inc adds one minute regardless of run; seconds are unaffected.
REQ-018 If min_inc and a seconds carry occur in the same cycle, minutes advance by 2 modulo 60 (e.g. 58 -> 00, 59 -> 01).
REQ-019 hour_tick is asserted for exactly the one cycle in which minutes pass through 59 -> 00 (including the +2 wrap); otherwise it is 0.
REQ-020 Scanner: 2-bit index advances 0->1->2->3->0 on each dig_edge.
REQ-021 Index map: 0 = sec_ones, an=1110; 1 = sec_tens, an=1101; 2 = min_ones, an=1011; 3 = min_tens, an=0111 (active-low values).
REQ-022 Seg encoding (active-low hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10; non-BCD value -> 7F.
REQ-023 With BLANK_LZ=1 and min_tens=0, index 3 drives seg=7F while an stays active.
REQ-024 dp is active only at index 2 while divided_clk=1 (colon blinks 50%); otherwise inactive.
REQ-025 an, seg and dp are registered; they reflect index and time values one cycle earlier; they are glitch-free with exactly one an bit active.
REQ-026 With COMMON_ANODE=0, an, seg and dp are the bitwise inverses of the REQ-021..024 values.

Reset
REQ-027 While rst=1: all BCD digits 0, index 0, hour_tick 0, an all inactive (1111), seg 7F, dp inactive (active-low values).
REQ-028 While rst=1, prev registers load the current input levels, so an input held high across reset release produces no spurious edge.
REQ-029 rst has priority over every event in the same cycle, including sec_edge, dig_edge and min_inc.
REQ-030 In the first cycle after release, index 0 is displayed (an=1110, seg=40).

Verification
REQ-031 Reset, run=1, 10 divided_clk rising edges -> mm_ss=0010; hour_tick never asserted.
REQ-032 Load 59:59 via 59 min_inc pulses and 59 second edges, then one more edge -> mm_ss=0000 and hour_tick high for exactly 1 cycle.
REQ-033 run=0, 5 second edges -> mm_ss unchanged; then 1 min_inc -> minutes +1.
REQ-034 At 12:59, min_inc coincident with sec_edge -> mm_ss=1400; at 58:59, the same stimulus -> mm_ss=0000 with hour_tick pulse.
REQ-035 Time 07:45, 4 digit_clk edges -> an 1110/1101/1011/0111 with seg 12/19/78/7F; dp low only at an=1011 while divided_clk=1.
REQ-036 Assert rst for 3 cycles while divided_clk is high mid-count, then release -> mm_ss=0000, with no increment until the next divided_clk rising edge.
